// File: rtl/cla_slice_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one 4-bit carry-lookahead
// slice per clock (LSB first), computed as a + ~b + ~bin. WIDTH must be a multiple of 4.
module cla_slice_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [3:0]       a_s;
  logic [3:0]       nb_s;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       c;
  logic [3:0]       s;
  logic             co;
  logic             last;
  logic [WIDTH-1:0] diff_new;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds its data until then. in_ready only in IDLE,
  // out_valid only in DONE, so one operation is in flight at a time.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign state_dbg = state;
  assign last      = (cnt == CW'(NSLICE - 1));

  always_comb begin
    a_s  = '0;
    nb_s = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_s  = a_q[4*k +: 4];
        nb_s = nb_q[4*k +: 4];
      end
    end

    g = a_s & nb_s;
    p = a_s ^ nb_s;

    // Full lookahead: every carry is a flat sum of products of the slice carry-in.
    c[0] = carry;
    c[1] = g[0] | (p[0] & carry);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    s    = p ^ c;

    diff_new = diff;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) diff_new[4*k +: 4] = s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      nb_q  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            nb_q  <= ~b;
            carry <= ~bin;
            diff  <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          diff  <= diff_new;
          carry <= co;
          if (last) begin
            // No carry out of a + ~b + ~bin means a borrow occurred.
            bout  <= ~co;
            ovf   <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (diff_new[WIDTH-1] != a_q[WIDTH-1]);
            zero  <= (diff_new == '0);
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
